// File: rtl/axi_rd_resp_if.sv
// AR/R channel and memory-port bundle for the AXI read responder.
// The slave modport is the responder's view; master is the requester/memory side.
interface axi_rd_resp_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 6
);
    logic              s_arvalid;
    logic              s_arready;
    logic [ID_W-1:0]   s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic              s_rvalid;
    logic              s_rready;
    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_rready, mem_rdata,
        output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, mem_rd, mem_addr
    );

    modport master (
        output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_rready, mem_rdata,
        input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, mem_rd, mem_addr
    );
endinterface

// File: rtl/axi_rd_resp.sv
// AXI read responder: queues AR requests in order and replays each as an INCR
// burst against a one-cycle-latency synchronous memory.
//   state | meaning
//   IDLE  | waiting for a queued request; pops the head when one is present
//   RD    | issue memory read for the current beat (suppressed on bad size)
//   CAP   | capture the returned word into the R data register
//   SEND  | present the beat on R and hold it until s_rready
module axi_rd_resp #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 6,
    parameter int AQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    axi_rd_resp_if.slave   bus,
    output logic           busy
);
    localparam int OFF = $clog2(DATA_W / 8);
    localparam int PW  = $clog2(AQ_DEPTH);
    localparam logic [2:0]        MAX_SIZE   = 3'(OFF);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << OFF) - 1));
    localparam logic [PW:0]       FULL_CNT   = (PW + 1)'(AQ_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

    logic [ID_W-1:0]   aq_id_q   [AQ_DEPTH];
    logic [ADDR_W-1:0] aq_addr_q [AQ_DEPTH];
    logic [7:0]        aq_len_q  [AQ_DEPTH];
    logic [2:0]        aq_size_q [AQ_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          arready, push, pop;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              last_beat;

    // Ready comes only from the registered count, never from the R side.
    assign arready = (count_q != FULL_CNT);
    assign push    = bus.s_arvalid && arready;

    always_ff @(posedge clk) begin
        if (push) begin
            aq_id_q[wr_ptr_q]   <= bus.s_arid;
            aq_addr_q[wr_ptr_q] <= bus.s_araddr;
            aq_len_q[wr_ptr_q]  <= bus.s_arlen;
            aq_size_q[wr_ptr_q] <= bus.s_arsize;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        id_d       = id_q;
        len_d      = len_q;
        size_d     = size_q;
        beat_d     = beat_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    cur_addr_d = aq_addr_q[rd_ptr_q];
                    id_d       = aq_id_q[rd_ptr_q];
                    len_d      = aq_len_q[rd_ptr_q];
                    size_d     = aq_size_q[rd_ptr_q];
                    beat_d     = '0;
                    err_d      = (aq_size_q[rd_ptr_q] > MAX_SIZE);
                    state_d    = RD;
                end
            end
            RD:   state_d = CAP;
            CAP: begin
                rdata_d = err_q ? '0 : bus.mem_rdata;
                state_d = SEND;
            end
            SEND: begin
                if (bus.s_rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cur_addr_d = cur_addr_q + (ADDR_W'(1) << size_q);
                        beat_d     = beat_q + 8'd1;
                        state_d    = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            cur_addr_q <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            size_q     <= size_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.s_arready = arready;
    assign bus.s_rvalid  = (state_q == SEND);
    assign bus.s_rid     = id_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = ((state_q == SEND) && err_q) ? 2'b10 : 2'b00;
    assign bus.s_rlast   = (state_q == SEND) && last_beat;
    assign bus.mem_rd    = (state_q == RD) && !err_q;
    assign bus.mem_addr  = cur_addr_q & ALIGN_MASK;
    assign busy          = (count_q != '0) || (state_q != IDLE);
endmodule
